// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch sequencer states and instruction size.
package cpu_pkg;

  localparam int INSTR_BYTES = 2;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    FS_F0,
    FS_L0,
    FS_F1,
    FS_L1,
    FS_DEC,
    FS_ISSUE,
    FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction handshake between the fetch sequencer (master) and execute (slave).
interface fetch_ctrl_if #(
  parameter int DW = 8
);
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [DW-1:0] instr_arg;

  modport master (output instr_valid, output instr_op, output instr_arg, input instr_ready);
  modport slave  (input instr_valid, input instr_op, input instr_arg, output instr_ready);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: reads 2-byte instructions, resolves JMP/SKZ/HLT locally and
// issues the rest to execute over a valid/ready handshake.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_en,
  output logic          pc_chg_en,
  output logic [AW-1:0] pc_chg_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  input  logic          zero_flag,
  fetch_ctrl_if.master  instr,
  input  logic          resume,
  output logic          halted
);

  fetch_state_t  state, next;
  logic [DW-1:0] ir_hi, ir_lo;
  logic [AW-1:0] chg_q, load_addr;
  logic          load;
  logic          started;
  logic [2:0]    op;
  logic          unused_ir;

  assign op        = ir_hi[DW-1 -: 3];
  assign unused_ir = ^ir_hi[DW-4:0];

  // Holds F0 quiet for the first cycle after reset so outputs are all-zero in reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) started <= 1'b0;
    else     started <= 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= FS_F0;
      ir_hi <= '0;
      ir_lo <= '0;
      chg_q <= '0;
    end else begin
      state <= next;
      if (state == FS_L0) ir_hi <= rom_data;
      if (state == FS_L1) ir_lo <= rom_data;
      if (load)           chg_q <= load_addr;
    end
  end

  always_comb begin
    next             = state;
    pc_en            = 1'b0;
    pc_chg_en        = 1'b0;
    rom_rd           = 1'b0;
    instr.instr_valid = 1'b0;
    halted           = 1'b0;
    load             = 1'b0;
    load_addr        = chg_q;
    unique case (state)
      FS_F0: if (started) begin
        rom_rd = 1'b1;
        next   = FS_L0;
      end
      FS_L0: begin
        pc_en = 1'b1;
        next  = FS_F1;
      end
      FS_F1: begin
        rom_rd = 1'b1;
        next   = FS_L1;
      end
      FS_L1: begin
        pc_en = 1'b1;
        next  = FS_DEC;
      end
      FS_DEC: begin
        if (op == OP_JMP) begin
          load      = 1'b1;
          load_addr = AW'(ir_lo);
          next      = FS_F0;
        end else if (op == OP_SKZ) begin
          // pc_addr already points past the SKZ; skip one more instruction.
          if (zero_flag) begin
            load      = 1'b1;
            load_addr = pc_addr + AW'(INSTR_BYTES);
          end
          next = FS_F0;
        end else if (op == OP_HLT) begin
          next = FS_HALT;
        end else begin
          next = FS_ISSUE;
        end
        pc_en     = load;
        pc_chg_en = load;
      end
      FS_ISSUE: begin
        instr.instr_valid = 1'b1;
        if (instr.instr_ready) next = FS_F0;
      end
      FS_HALT: begin
        halted = 1'b1;
        if (resume) next = FS_F0;
      end
      default: next = FS_F0;
    endcase
  end

  assign pc_chg_addr     = load ? load_addr : chg_q;
  assign instr.instr_op  = op;
  assign instr.instr_arg = ir_lo;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC and synchronous ROM.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] pc_addr;
  logic       pc_en, pc_chg_en, rom_rd, zero_flag, resume, halted;
  logic [7:0] pc_chg_addr, rom_data;
  logic [7:0] rom [256];
  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         xfer_cnt = 0;

  fetch_ctrl_if #(.DW(8)) bus ();

  fetch_ctrl #(.DW(8), .AW(8)) dut (
    .clock       (clock),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_en       (pc_en),
    .pc_chg_en   (pc_chg_en),
    .pc_chg_addr (pc_chg_addr),
    .rom_rd      (rom_rd),
    .rom_data    (rom_data),
    .zero_flag   (zero_flag),
    .instr       (bus.master),
    .resume      (resume),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  // Program counter with its own active-low reset tied to ~rst.
  wire rst_n = ~rst;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)         pc_addr <= 8'h00;
    else if (pc_en)     pc_addr <= pc_chg_en ? pc_chg_addr : pc_addr + 8'h01;
  end

  always @(posedge clock) if (rom_rd) rom_data <= rom[pc_addr];

  always @(negedge clock) begin
    if (bus.instr_valid)                    valid_cnt++;
    if (bus.instr_valid && bus.instr_ready) xfer_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if ({rom_rd, pc_en, pc_chg_en, bus.instr_valid, halted} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 00000", {rom_rd, pc_en, pc_chg_en, bus.instr_valid, halted}); end
    checks++; if ({pc_chg_addr, bus.instr_op, bus.instr_arg} !== 19'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h exp 0", pc_chg_addr, bus.instr_op, bus.instr_arg); end
    rst = 1'b0;
    checks++; if (rom_rd !== 1'b0) begin
      errors++; $display("FAIL reset_release_rom_rd: got %b exp 0", rom_rd); end
  endtask

  task automatic test_lda();
    valid_cnt = 0;
    step();
    checks++; if (rom_rd !== 1'b1 || pc_addr !== 8'h00 || pc_en !== 1'b0) begin
      errors++; $display("FAIL lda_c0: rom_rd=%b pc=%h pc_en=%b exp 1/00/0", rom_rd, pc_addr, pc_en); end
    step();
    checks++; if (pc_en !== 1'b1 || pc_chg_en !== 1'b0 || rom_rd !== 1'b0) begin
      errors++; $display("FAIL lda_c1: pc_en=%b chg=%b rom_rd=%b exp 1/0/0", pc_en, pc_chg_en, rom_rd); end
    step();
    checks++; if (rom_rd !== 1'b1 || pc_addr !== 8'h01) begin
      errors++; $display("FAIL lda_c2: rom_rd=%b pc=%h exp 1/01", rom_rd, pc_addr); end
    step();
    checks++; if (pc_en !== 1'b1 || pc_chg_en !== 1'b0) begin
      errors++; $display("FAIL lda_c3: pc_en=%b chg=%b exp 1/0", pc_en, pc_chg_en); end
    step();
    checks++; if ({pc_en, rom_rd, bus.instr_valid} !== 3'b000) begin
      errors++; $display("FAIL lda_c4_dec: got %b exp 000", {pc_en, rom_rd, bus.instr_valid}); end
    step();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_op !== 3'b101 || bus.instr_arg !== 8'h10) begin
      errors++; $display("FAIL lda_c5_issue: valid=%b op=%b arg=%h exp 1/101/10", bus.instr_valid, bus.instr_op, bus.instr_arg); end
    step();
    checks++; if (rom_rd !== 1'b1 || pc_addr !== 8'h02 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL lda_c6: rom_rd=%b pc=%h valid=%b exp 1/02/0", rom_rd, pc_addr, bus.instr_valid); end
    checks++; if (valid_cnt != 1) begin
      errors++; $display("FAIL lda_valid_cycles: got %0d exp 1", valid_cnt); end
  endtask

  task automatic test_jmp();
    valid_cnt = 0;
    steps(4);
    checks++; if (pc_en !== 1'b1 || pc_chg_en !== 1'b1 || pc_chg_addr !== 8'h40) begin
      errors++; $display("FAIL jmp_dec: pc_en=%b chg=%b addr=%h exp 1/1/40", pc_en, pc_chg_en, pc_chg_addr); end
    step();
    checks++; if (pc_addr !== 8'h40 || rom_rd !== 1'b1) begin
      errors++; $display("FAIL jmp_fetch: pc=%h rom_rd=%b exp 40/1", pc_addr, rom_rd); end
    checks++; if (valid_cnt != 0) begin
      errors++; $display("FAIL jmp_no_valid: got %0d exp 0", valid_cnt); end
  endtask

  task automatic test_skz();
    steps(5);
    checks++; if (pc_addr !== 8'hFE) begin
      errors++; $display("FAIL skz_at_fe: pc=%h exp fe", pc_addr); end
    zero_flag = 1'b1;
    steps(4);
    checks++; if (pc_addr !== 8'h00 || pc_en !== 1'b1 || pc_chg_en !== 1'b1 || pc_chg_addr !== 8'h02) begin
      errors++; $display("FAIL skz_taken_dec: pc=%h en=%b chg=%b addr=%h exp 00/1/1/02", pc_addr, pc_en, pc_chg_en, pc_chg_addr); end
    step();
    checks++; if (pc_addr !== 8'h02 || rom_rd !== 1'b1) begin
      errors++; $display("FAIL skz_taken_fetch: pc=%h rom_rd=%b exp 02/1", pc_addr, rom_rd); end
    zero_flag = 1'b0;
    steps(5);
    steps(4);
    checks++; if (pc_en !== 1'b0 || pc_chg_en !== 1'b0 || pc_chg_addr !== 8'hFE) begin
      errors++; $display("FAIL skz_not_taken_dec: en=%b chg=%b addr=%h exp 0/0/fe", pc_en, pc_chg_en, pc_chg_addr); end
    step();
    checks++; if (pc_addr !== 8'h00 || rom_rd !== 1'b1) begin
      errors++; $display("FAIL skz_not_taken_fetch: pc=%h rom_rd=%b exp 00/1", pc_addr, rom_rd); end
  endtask

  task automatic test_add_stall();
    rom[8'h00] = 8'h40;
    rom[8'h01] = 8'h5A;
    bus.instr_ready = 1'b0;
    xfer_cnt = 0;
    steps(4);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_op !== OP_ADD || bus.instr_arg !== 8'h5A || rom_rd !== 1'b0) begin
        errors++; $display("FAIL add_stall_%0d: valid=%b op=%b arg=%h rom_rd=%b exp 1/010/5a/0", i, bus.instr_valid, bus.instr_op, bus.instr_arg, rom_rd); end
      if (i == 4) bus.instr_ready = 1'b1;
    end
    step();
    checks++; if (bus.instr_valid !== 1'b0 || rom_rd !== 1'b1 || pc_addr !== 8'h02) begin
      errors++; $display("FAIL add_return: valid=%b rom_rd=%b pc=%h exp 0/1/02", bus.instr_valid, rom_rd, pc_addr); end
    checks++; if (xfer_cnt != 1) begin
      errors++; $display("FAIL add_transfers: got %0d exp 1", xfer_cnt); end
  endtask

  task automatic test_halt_resume();
    int busy;
    steps(5);
    steps(4);
    step();
    checks++; if (halted !== 1'b1 || pc_addr !== 8'h22) begin
      errors++; $display("FAIL halt_enter: halted=%b pc=%h exp 1/22", halted, pc_addr); end
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rom_rd || pc_en || !halted) busy++;
    end
    checks++; if (busy != 0 || pc_addr !== 8'h22) begin
      errors++; $display("FAIL halt_idle: active_cycles=%0d pc=%h exp 0/22", busy, pc_addr); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++; if (halted !== 1'b0 || rom_rd !== 1'b1 || pc_addr !== 8'h22) begin
      errors++; $display("FAIL halt_resume: halted=%b rom_rd=%b pc=%h exp 0/1/22", halted, rom_rd, pc_addr); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    checks++; if (pc_en !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL resume_ignored_l0: pc_en=%b halted=%b exp 1/0", pc_en, halted); end
    steps(3);
    checks++; if (pc_chg_en !== 1'b1 || pc_chg_addr !== 8'h24) begin
      errors++; $display("FAIL resume_ignored_dec: chg=%b addr=%h exp 1/24", pc_chg_en, pc_chg_addr); end
    step();
    checks++; if (pc_addr !== 8'h24 || rom_rd !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL resume_ignored_fetch: pc=%h rom_rd=%b halted=%b exp 24/1/0", pc_addr, rom_rd, halted); end
  endtask

  task automatic test_reset_mid();
    bus.instr_ready = 1'b0;
    steps(5);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_arg !== 8'h33) begin
      errors++; $display("FAIL rstmid_issue: valid=%b arg=%h exp 1/33", bus.instr_valid, bus.instr_arg); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.instr_valid, halted, rom_rd, pc_en} !== 4'b0 || bus.instr_op !== 3'b000 || bus.instr_arg !== 8'h00 || pc_chg_addr !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: ctrl=%b op=%b arg=%h addr=%h exp 0000/000/00/00", {bus.instr_valid, halted, rom_rd, pc_en}, bus.instr_op, bus.instr_arg, pc_chg_addr); end
    steps(2);
    rst = 1'b0;
    checks++; if (rom_rd !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: rom_rd=%b exp 0", rom_rd); end
    step();
    checks++; if (rom_rd !== 1'b1 || pc_addr !== 8'h00 || bus.instr_op !== 3'b000 || bus.instr_arg !== 8'h00) begin
      errors++; $display("FAIL rstmid_refetch: rom_rd=%b pc=%h op=%b arg=%h exp 1/00/000/00", rom_rd, pc_addr, bus.instr_op, bus.instr_arg); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'hA0; rom[8'h01] = 8'h10;
    rom[8'h02] = 8'hE0; rom[8'h03] = 8'h40;
    rom[8'h40] = 8'hE0; rom[8'h41] = 8'hFE;
    rom[8'hFE] = 8'h20; rom[8'hFF] = 8'h00;
    rom[8'h20] = 8'h00; rom[8'h21] = 8'h00;
    rom[8'h22] = 8'hE0; rom[8'h23] = 8'h24;
    rom[8'h24] = 8'h40; rom[8'h25] = 8'h33;
    rst = 1'b1;
    zero_flag = 1'b0;
    resume = 1'b0;
    bus.instr_ready = 1'b1;

    test_reset();
    test_lda();
    test_jmp();
    rom[8'h02] = 8'hE0; rom[8'h03] = 8'hFE;
    test_skz();
    test_add_stall();
    rom[8'h02] = 8'hE0; rom[8'h03] = 8'h20;
    test_halt_resume();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
